// File: rtl/pipe_control_seq.sv
// Pipelined MIPS main decoder with ID-stage steering, ID/EX control register
// and a start/stall/writeback-guard sequencer for multi-cycle SPEC ops.
module pipe_control_seq #(
   parameter int MC_TIMEOUT = 64,
   parameter bit HAS_BNE    = 1'b1,
   parameter bit HAS_JAL    = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] opcode,
   input  logic       id_valid,
   input  logic       branch_eq,
   input  logic       mc_done,
   output logic [1:0] if_pc_source,
   output logic       id_rt_is_source,
   output logic       if_flush,
   output logic       stall,
   output logic       ex_imm_command,
   output logic       ex_alu_src_b,
   output logic [1:0] ex_dst_reg_sel,
   output logic [1:0] ex_alu_op,
   output logic       ex_link,
   output logic       mem_read,
   output logic       mem_write,
   output logic       wb_mem_to_reg,
   output logic       wb_reg_write,
   output logic       mc_start,
   output logic       mc_err
);

   localparam int CW = $clog2(MC_TIMEOUT + 1);

   localparam logic [5:0] OP_R    = 6'd0;
   localparam logic [5:0] OP_J    = 6'd2;
   localparam logic [5:0] OP_JAL  = 6'd3;
   localparam logic [5:0] OP_BEQ  = 6'd4;
   localparam logic [5:0] OP_BNE  = 6'd5;
   localparam logic [5:0] OP_ADDI = 6'd8;
   localparam logic [5:0] OP_SLTI = 6'd10;
   localparam logic [5:0] OP_ANDI = 6'd12;
   localparam logic [5:0] OP_ORI  = 6'd13;
   localparam logic [5:0] OP_XORI = 6'd14;
   localparam logic [5:0] OP_SPEC = 6'b011100;
   localparam logic [5:0] OP_LW   = 6'd35;
   localparam logic [5:0] OP_SW   = 6'd43;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DRAIN = 2'd3
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [CW-1:0] count;
   logic          is_spec;
   logic          timeout;
   logic          active;

   logic          d_imm;
   logic          d_srcb;
   logic [1:0]    d_dst;
   logic [1:0]    d_op;
   logic          d_link;
   logic          d_mr;
   logic          d_mw;
   logic          d_m2r;
   logic          d_wr;

   assign is_spec = (opcode == OP_SPEC);
   assign timeout = (count == CW'(MC_TIMEOUT - 1));

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:  if (id_valid && is_spec) state_nxt = ISSUE;
         ISSUE: state_nxt = WAIT;
         WAIT:  if (mc_done || timeout) state_nxt = DRAIN;
         DRAIN: state_nxt = (id_valid && is_spec) ? ISSUE : IDLE;
      endcase
   end

   // state-derived outputs
   always_comb begin
      stall    = 1'b0;
      mc_start = 1'b0;
      unique case (state)
         IDLE:  ;
         ISSUE: begin
            stall    = 1'b1;
            mc_start = 1'b1;
         end
         WAIT:  stall = 1'b1;
         DRAIN: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count  <= '0;
         mc_err <= 1'b0;
      end else begin
         if (state == ISSUE) begin
            count <= '0;
         end else if (state == WAIT) begin
            count <= count + CW'(1);
         end
         if (state == WAIT && !mc_done && timeout) begin
            mc_err <= 1'b1;
         end
      end
   end

   // ID/EX control decode
   always_comb begin
      d_imm  = 1'b0;
      d_srcb = 1'b0;
      d_dst  = 2'b00;
      d_op   = 2'b00;
      d_link = 1'b0;
      d_mr   = 1'b0;
      d_mw   = 1'b0;
      d_m2r  = 1'b0;
      d_wr   = 1'b0;
      case (opcode)
         OP_R: begin
            d_dst = 2'b01;
            d_op  = 2'b10;
            d_wr  = 1'b1;
         end
         OP_LW: begin
            d_srcb = 1'b1;
            d_mr   = 1'b1;
            d_m2r  = 1'b1;
            d_wr   = 1'b1;
         end
         OP_SW: begin
            d_srcb = 1'b1;
            d_mw   = 1'b1;
            d_m2r  = 1'b1;
         end
         OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI: begin
            d_imm  = 1'b1;
            d_srcb = 1'b1;
            d_op   = 2'b10;
            d_wr   = 1'b1;
         end
         OP_JAL: begin
            if (HAS_JAL) begin
               d_dst  = 2'b10;
               d_link = 1'b1;
               d_wr   = 1'b1;
            end
         end
         // writeback enabled only once the extended unit commits
         OP_SPEC: begin
            d_dst = 2'b01;
            d_op  = 2'b11;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_imm_command <= 1'b0;
         ex_alu_src_b   <= 1'b0;
         ex_dst_reg_sel <= 2'b00;
         ex_alu_op      <= 2'b00;
         ex_link        <= 1'b0;
         mem_read       <= 1'b0;
         mem_write      <= 1'b0;
         wb_mem_to_reg  <= 1'b0;
         wb_reg_write   <= 1'b0;
      end else if (!stall) begin
         ex_imm_command <= id_valid & d_imm;
         ex_alu_src_b   <= id_valid & d_srcb;
         ex_dst_reg_sel <= id_valid ? d_dst : 2'b00;
         ex_alu_op      <= id_valid ? d_op : 2'b00;
         ex_link        <= id_valid & d_link;
         mem_read       <= id_valid & d_mr;
         mem_write      <= id_valid & d_mw;
         wb_mem_to_reg  <= id_valid & d_m2r;
         wb_reg_write   <= id_valid & d_wr;
      end else if (state == WAIT && (mc_done || timeout)) begin
         wb_reg_write <= mc_done;
      end
   end

   // ID-stage steering, suppressed while stalled
   assign active = id_valid & ~stall;

   always_comb begin
      if_pc_source = 2'b00;
      if (active) begin
         case (opcode)
            OP_BEQ: if (branch_eq) if_pc_source = 2'b01;
            OP_BNE: if (HAS_BNE && !branch_eq) if_pc_source = 2'b01;
            OP_J, OP_JAL: if_pc_source = 2'b10;
            default: ;
         endcase
      end
   end

   assign id_rt_is_source = active & ((opcode == OP_R) |
                                      (opcode == OP_BEQ) |
                                      ((opcode == OP_BNE) & HAS_BNE) |
                                      (opcode == OP_SW) |
                                      is_spec);

   assign if_flush = active & (if_pc_source != 2'b00);

endmodule

// File: tb/tb_pipe_control_seq.sv
// Scoreboard bench for pipe_control_seq: directed per-cycle vectors push
// hand-computed expected outputs, a negedge monitor pops and compares.
module tb_pipe_control_seq;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [5:0] opcode = 6'd0;
   logic       id_valid = 1'b0;
   logic       branch_eq = 1'b0;
   logic       mc_done = 1'b0;
   logic [1:0] if_pc_source;
   logic       id_rt_is_source;
   logic       if_flush;
   logic       stall;
   logic       ex_imm_command;
   logic       ex_alu_src_b;
   logic [1:0] ex_dst_reg_sel;
   logic [1:0] ex_alu_op;
   logic       ex_link;
   logic       mem_read;
   logic       mem_write;
   logic       wb_mem_to_reg;
   logic       wb_reg_write;
   logic       mc_start;
   logic       mc_err;

   pipe_control_seq #(
      .MC_TIMEOUT(4),
      .HAS_BNE(1'b1),
      .HAS_JAL(1'b1)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .opcode(opcode),
      .id_valid(id_valid),
      .branch_eq(branch_eq),
      .mc_done(mc_done),
      .if_pc_source(if_pc_source),
      .id_rt_is_source(id_rt_is_source),
      .if_flush(if_flush),
      .stall(stall),
      .ex_imm_command(ex_imm_command),
      .ex_alu_src_b(ex_alu_src_b),
      .ex_dst_reg_sel(ex_dst_reg_sel),
      .ex_alu_op(ex_alu_op),
      .ex_link(ex_link),
      .mem_read(mem_read),
      .mem_write(mem_write),
      .wb_mem_to_reg(wb_mem_to_reg),
      .wb_reg_write(wb_reg_write),
      .mc_start(mc_start),
      .mc_err(mc_err)
   );

   always #5 clk = ~clk;

   localparam logic [5:0] R    = 6'd0;
   localparam logic [5:0] J    = 6'd2;
   localparam logic [5:0] JAL  = 6'd3;
   localparam logic [5:0] BEQ  = 6'd4;
   localparam logic [5:0] BNE  = 6'd5;
   localparam logic [5:0] ADDI = 6'd8;
   localparam logic [5:0] SPEC = 6'b011100;
   localparam logic [5:0] LW   = 6'd35;
   localparam logic [5:0] SW   = 6'd43;

   // {imm, srcb, dst[1:0], op[1:0], link, mr, mw, m2r, wr}
   localparam logic [10:0] X_NOP = 11'b0_0_00_00_0_0_0_0_0;
   localparam logic [10:0] X_LW  = 11'b0_1_00_00_0_1_0_1_1;
   localparam logic [10:0] X_SW  = 11'b0_1_00_00_0_0_1_1_0;
   localparam logic [10:0] X_R   = 11'b0_0_01_10_0_0_0_0_1;
   localparam logic [10:0] X_I   = 11'b1_1_00_10_0_0_0_0_1;
   localparam logic [10:0] X_JAL = 11'b0_0_10_00_1_0_0_0_1;
   localparam logic [10:0] X_SP0 = 11'b0_0_01_11_0_0_0_0_0;
   localparam logic [10:0] X_SP1 = 11'b0_0_01_11_0_0_0_0_1;

   // {pcs[1:0], rt, flush, stall, start, err, idex[10:0]}
   logic [17:0] exp_q[$];
   int          tag_q[$];
   int          checks = 0;
   int          errors = 0;
   int          step_no = 0;

   wire [17:0] got = {if_pc_source, id_rt_is_source, if_flush, stall,
                      mc_start, mc_err,
                      ex_imm_command, ex_alu_src_b, ex_dst_reg_sel,
                      ex_alu_op, ex_link, mem_read, mem_write,
                      wb_mem_to_reg, wb_reg_write};

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         logic [17:0] e;
         int          t;
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL step%0d: got %b expected %b", t, got, e);
         end
      end
   end

   task automatic cyc(input logic rst, input logic [5:0] op,
                      input logic v, input logic beq, input logic done,
                      input logic [1:0] pcs, input logic rt,
                      input logic fl, input logic st, input logic sta,
                      input logic er, input logic [10:0] x);
      @(posedge clk);
      #1;
      rst_n     = rst;
      opcode    = op;
      id_valid  = v;
      branch_eq = beq;
      mc_done   = done;
      step_no++;
      exp_q.push_back({pcs, rt, fl, st, sta, er, x});
      tag_q.push_back(step_no);
   endtask

   initial begin
      //  rst op    v  beq dn  pcs    rt fl st sa er idex
      cyc(0, R,    0, 0,  0, 2'b00, 0, 0, 0, 0, 0, X_NOP);
      cyc(1, LW,   1, 0,  0, 2'b00, 0, 0, 0, 0, 0, X_NOP);
      cyc(1, ADDI, 1, 0,  0, 2'b00, 0, 0, 0, 0, 0, X_LW);
      cyc(1, SW,   1, 0,  0, 2'b00, 1, 0, 0, 0, 0, X_I);
      cyc(1, R,    1, 0,  0, 2'b00, 1, 0, 0, 0, 0, X_SW);
      cyc(1, BEQ,  1, 1,  0, 2'b01, 1, 1, 0, 0, 0, X_R);
      cyc(1, BNE,  1, 1,  0, 2'b00, 1, 0, 0, 0, 0, X_NOP);
      cyc(1, BNE,  1, 0,  0, 2'b01, 1, 1, 0, 0, 0, X_NOP);
      cyc(1, JAL,  1, 0,  0, 2'b10, 0, 1, 0, 0, 0, X_NOP);
      cyc(1, J,    1, 0,  0, 2'b10, 0, 1, 0, 0, 0, X_JAL);
      cyc(1, BEQ,  0, 1,  0, 2'b00, 0, 0, 0, 0, 0, X_NOP);
      // SPEC commit, mc_done 3 cycles after mc_start, taken BEQ held in ID
      cyc(1, SPEC, 1, 0,  0, 2'b00, 1, 0, 0, 0, 0, X_NOP);
      cyc(1, BEQ,  1, 1,  0, 2'b00, 0, 0, 1, 1, 0, X_SP0);
      cyc(1, BEQ,  1, 1,  0, 2'b00, 0, 0, 1, 0, 0, X_SP0);
      cyc(1, BEQ,  1, 1,  0, 2'b00, 0, 0, 1, 0, 0, X_SP0);
      cyc(1, BEQ,  1, 1,  1, 2'b00, 0, 0, 1, 0, 0, X_SP0);
      cyc(1, BEQ,  1, 1,  0, 2'b01, 1, 1, 0, 0, 0, X_SP1);
      // SPEC with mc_done in the timeout cycle: commit wins
      cyc(1, SPEC, 1, 0,  0, 2'b00, 1, 0, 0, 0, 0, X_NOP);
      cyc(1, R,    0, 0,  0, 2'b00, 0, 0, 1, 1, 0, X_SP0);
      cyc(1, R,    0, 0,  0, 2'b00, 0, 0, 1, 0, 0, X_SP0);
      cyc(1, R,    0, 0,  0, 2'b00, 0, 0, 1, 0, 0, X_SP0);
      cyc(1, R,    0, 0,  0, 2'b00, 0, 0, 1, 0, 0, X_SP0);
      cyc(1, R,    0, 0,  1, 2'b00, 0, 0, 1, 0, 0, X_SP0);
      // DRAIN with back-to-back SPEC in ID
      cyc(1, SPEC, 1, 0,  0, 2'b00, 1, 0, 0, 0, 0, X_SP1);
      // timeout abort
      cyc(1, R,    0, 0,  0, 2'b00, 0, 0, 1, 1, 0, X_SP0);
      cyc(1, R,    0, 0,  0, 2'b00, 0, 0, 1, 0, 0, X_SP0);
      cyc(1, R,    0, 0,  0, 2'b00, 0, 0, 1, 0, 0, X_SP0);
      cyc(1, R,    0, 0,  0, 2'b00, 0, 0, 1, 0, 0, X_SP0);
      cyc(1, R,    0, 0,  0, 2'b00, 0, 0, 1, 0, 0, X_SP0);
      cyc(1, R,    0, 0,  0, 2'b00, 0, 0, 0, 0, 1, X_SP0);
      cyc(1, R,    0, 0,  0, 2'b00, 0, 0, 0, 0, 1, X_NOP);
      // reset during WAIT
      cyc(1, SPEC, 1, 0,  0, 2'b00, 1, 0, 0, 0, 1, X_NOP);
      cyc(1, R,    0, 0,  0, 2'b00, 0, 0, 1, 1, 1, X_SP0);
      cyc(1, R,    0, 0,  0, 2'b00, 0, 0, 1, 0, 1, X_SP0);
      cyc(0, R,    0, 0,  0, 2'b00, 0, 0, 0, 0, 0, X_NOP);
      cyc(1, R,    0, 0,  0, 2'b00, 0, 0, 0, 0, 0, X_NOP);
      cyc(1, R,    0, 0,  0, 2'b00, 0, 0, 0, 0, 0, X_NOP);
      @(negedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d pending, expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
